// File: rtl/dp_pkg.sv
// Shared datapath definitions: ALU opcodes and the default-width write-back record.
package dp_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    localparam int unsigned DP_DATA_W = 8;
    localparam int unsigned DP_ADDR_W = 4;

    // Write-back record for the default ProtoCore configuration (8-bit, 16 registers)
    typedef struct packed {
        logic                 we;
        logic [DP_ADDR_W-1:0] addr;
        logic [DP_DATA_W-1:0] data;
    } wb_rec_t;

endpackage

// File: rtl/datapath_pipe_if.sv
// Issue/result bus between the control unit (master) and the pipelined datapath (slave).
interface datapath_pipe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              issue_valid;
    logic              issue_ready;
    logic              stall;
    logic [2:0]        alu_opcode;
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic [ADDR_W-1:0] write_addr;
    logic              write_en;
    logic              is_load;
    logic              imm_flag;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] imm_data;
    logic [DATA_W-1:0] read_a;
    logic [DATA_W-1:0] read_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              alu_carry;
    logic              result_valid;

    modport master (
        output issue_valid, stall, alu_opcode, ra_addr, rb_addr, write_addr,
               write_en, is_load, imm_flag, ram_data, imm_data,
        input  issue_ready, read_a, read_b, alu_out, alu_zero, alu_carry, result_valid
    );

    modport slave (
        input  issue_valid, stall, alu_opcode, ra_addr, rb_addr, write_addr,
               write_en, is_load, imm_flag, ram_data, imm_data,
        output issue_ready, read_a, read_b, alu_out, alu_zero, alu_carry, result_valid
    );
endinterface

// File: rtl/datapath_pipe_alu_core.sv
// Combinational 8-op ALU producing result, zero and carry/borrow.
module alu_core
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
            // The extra MSB of the widened difference is the unsigned borrow
            OP_SUB: begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin result = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; end
            OP_SHR: begin result = {1'b0, a[DATA_W-1:1]}; carry = a[0];        end
            default: ;
        endcase
        zero = (result == '0);
    end
endmodule

// File: rtl/datapath_pipe.sv
// Pipelined datapath: register file, operand select, ALU, EX and WB stages.
// DATAPATH_FWD_EN selects WB->EX forwarding; otherwise RAW hazards insert a one-cycle bubble.
module datapath_pipe
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned REG_CNT = 16,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    datapath_pipe_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(REG_CNT);

    // Width-matched copy of dp_pkg::wb_rec_t for this parametrisation
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic [DATA_W-1:0] rf [REG_CNT];
    wb_t               wb_q;
    wb_t               wb_n;
    logic [DATA_W-1:0] read_a_q;
    logic [DATA_W-1:0] read_b_q;
    logic [DATA_W-1:0] alu_out_q;
    logic              alu_zero_q;
    logic              alu_carry_q;
    logic              result_valid_q;

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero_c;
    logic              alu_carry_c;
    logic              hazard_c;
    logic              issue_ready_c;
    logic              xfer_c;

    // Register 0 is never written when hard-wired, so it also never forwards
    assign rf_a = rf[bus.ra_addr];
    assign rf_b = rf[bus.rb_addr];

`ifdef DATAPATH_FWD_EN
    logic fwd_a_c;
    logic fwd_b_c;

    assign fwd_a_c  = wb_q.we && (wb_q.addr == bus.ra_addr);
    assign fwd_b_c  = wb_q.we && (wb_q.addr == bus.rb_addr);
    assign op_a     = fwd_a_c ? wb_q.data : rf_a;
    assign op_b     = bus.imm_flag ? bus.imm_data : (fwd_b_c ? wb_q.data : rf_b);
    assign hazard_c = 1'b0;
`else
    assign op_a     = rf_a;
    assign op_b     = bus.imm_flag ? bus.imm_data : rf_b;
    assign hazard_c = wb_q.we && ((wb_q.addr == bus.ra_addr) ||
                                  (!bus.imm_flag && (wb_q.addr == bus.rb_addr)));
`endif

    assign issue_ready_c = rst_n & ~bus.stall & ~hazard_c;
    assign xfer_c        = bus.issue_valid & issue_ready_c;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op_e'(bus.alu_opcode)),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res),
        .zero   (alu_zero_c),
        .carry  (alu_carry_c)
    );

    always_comb begin
        wb_n      = '0;
        wb_n.we   = bus.write_en && !(R0_ZERO && (bus.write_addr == '0));
        wb_n.addr = bus.write_addr;
        wb_n.data = bus.is_load ? bus.ram_data : alu_res;
    end

    // EX/WB pipeline registers and register file; stall freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf             <= '{default: '0};
            wb_q           <= '0;
            read_a_q       <= '0;
            read_b_q       <= '0;
            alu_out_q      <= '0;
            alu_zero_q     <= 1'b0;
            alu_carry_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else if (bus.stall) begin
            result_valid_q <= 1'b0;
        end else begin
            if (wb_q.we) begin
                rf[wb_q.addr] <= wb_q.data;
            end
            result_valid_q <= xfer_c;
            if (xfer_c) begin
                read_a_q <= op_a;
                read_b_q <= op_b;
                wb_q     <= wb_n;
                if (!bus.is_load) begin
                    alu_out_q   <= alu_res;
                    alu_zero_q  <= alu_zero_c;
                    alu_carry_q <= alu_carry_c;
                end
            end else begin
                wb_q.we <= 1'b0;
            end
        end
    end

    assign bus.issue_ready  = issue_ready_c;
    assign bus.read_a       = read_a_q;
    assign bus.read_b       = read_b_q;
    assign bus.alu_out      = alu_out_q;
    assign bus.alu_zero     = alu_zero_q;
    assign bus.alu_carry    = alu_carry_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed self-checking bench for datapath_pipe: default 8-bit instance and a
// 16-bit / 32-register instance with R0 hard-wired to zero.
module tb_datapath_pipe;
    import dp_pkg::*;

`ifdef DATAPATH_FWD_EN
    localparam int EXP_BUB = 0;
`else
    localparam int EXP_BUB = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   nb;

    always #5 clk = ~clk;

    datapath_pipe_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();
    datapath_pipe_if #(.DATA_W(16), .ADDR_W(5)) bus16 ();

    datapath_pipe #(.DATA_W(8), .REG_CNT(16), .R0_ZERO(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );
    datapath_pipe #(.DATA_W(16), .REG_CNT(32), .R0_ZERO(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue8(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] wa, input logic we, input logic ld, input logic immf,
                          input logic [7:0] ram, input logic [7:0] imm, output int bub);
        @(negedge clk);
        bus8.alu_opcode = op;  bus8.ra_addr = ra;   bus8.rb_addr = rb;
        bus8.write_addr = wa;  bus8.write_en = we;  bus8.is_load = ld;
        bus8.imm_flag   = immf; bus8.ram_data = ram; bus8.imm_data = imm;
        bus8.issue_valid = 1'b1;
        bub = 0;
        #1;
        while (!bus8.issue_ready && bub < 4) begin
            @(negedge clk); #1;
            bub++;
        end
        chk("issue8_ready", 32'(bus8.issue_ready), 32'd1);
        @(posedge clk); #1;
        bus8.issue_valid = 1'b0;
        chk("issue8_result_valid", 32'(bus8.result_valid), 32'd1);
    endtask

    task automatic issue16(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [4:0] wa, input logic we, input logic immf,
                           input logic [15:0] imm);
        int bub;
        @(negedge clk);
        bus16.alu_opcode = op;  bus16.ra_addr = ra;   bus16.rb_addr = rb;
        bus16.write_addr = wa;  bus16.write_en = we;  bus16.is_load = 1'b0;
        bus16.imm_flag   = immf; bus16.ram_data = '0; bus16.imm_data = imm;
        bus16.issue_valid = 1'b1;
        bub = 0;
        #1;
        while (!bus16.issue_ready && bub < 4) begin
            @(negedge clk); #1;
            bub++;
        end
        chk("issue16_ready", 32'(bus16.issue_ready), 32'd1);
        @(posedge clk); #1;
        bus16.issue_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus8.stall = 1'b0;  bus8.alu_opcode = '0; bus8.ra_addr = '0; bus8.rb_addr = '0;
        bus8.write_addr = '0; bus8.write_en = 1'b0; bus8.is_load = 1'b0; bus8.imm_flag = 1'b0;
        bus8.ram_data = '0; bus8.imm_data = '0; bus8.issue_valid = 1'b1;
        bus16.stall = 1'b0; bus16.alu_opcode = '0; bus16.ra_addr = '0; bus16.rb_addr = '0;
        bus16.write_addr = '0; bus16.write_en = 1'b0; bus16.is_load = 1'b0; bus16.imm_flag = 1'b0;
        bus16.ram_data = '0; bus16.imm_data = '0; bus16.issue_valid = 1'b1;

        // Reset held with issue_valid high
        @(posedge clk); @(posedge clk); #1;
        chk("rst_read_a",       32'(bus8.read_a),       32'h0);
        chk("rst_read_b",       32'(bus8.read_b),       32'h0);
        chk("rst_alu_out",      32'(bus8.alu_out),      32'h0);
        chk("rst_zero",         32'(bus8.alu_zero),     32'h0);
        chk("rst_carry",        32'(bus8.alu_carry),    32'h0);
        chk("rst_result_valid", 32'(bus8.result_valid), 32'h0);
        chk("rst_issue_ready",  32'(bus8.issue_ready),  32'h0);
        chk("rst_issue_ready16", 32'(bus16.issue_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus8.issue_valid = 1'b0;
        bus16.issue_valid = 1'b0;

        issue8(OP_OR, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, nb);
        chk("r3_after_reset", 32'(bus8.read_a), 32'h00);

        // Load r1 then ADD using r1 the very next cycle
        issue8(OP_ADD, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b1, 8'h0F, 8'h00, nb);
        chk("load_alu_hold",  32'(bus8.alu_out),  32'h00);
        chk("load_zero_hold", 32'(bus8.alu_zero), 32'h1);
        issue8(OP_ADD, 4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 8'h00, 8'hF1, nb);
        chk("fwd_bubbles", 32'(nb),             32'(EXP_BUB));
        chk("fwd_read_a",  32'(bus8.read_a),    32'h0F);
        chk("fwd_read_b",  32'(bus8.read_b),    32'hF1);
        chk("add_out",     32'(bus8.alu_out),   32'h00);
        chk("add_zero",    32'(bus8.alu_zero),  32'h1);
        chk("add_carry",   32'(bus8.alu_carry), 32'h1);
        @(posedge clk); #1;
        chk("idle_result_valid", 32'(bus8.result_valid), 32'h0);
        chk("idle_alu_hold",     32'(bus8.alu_out),      32'h00);

        // SUB with borrow
        issue8(OP_ADD, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b1, 8'h05, 8'h00, nb);
        issue8(OP_ADD, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b1, 8'h07, 8'h00, nb);
        issue8(OP_SUB, 4'd4, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, nb);
        chk("sub_read_b", 32'(bus8.read_b),    32'h07);
        chk("sub_out",    32'(bus8.alu_out),   32'hFE);
        chk("sub_borrow", 32'(bus8.alu_carry), 32'h1);
        chk("sub_zero",   32'(bus8.alu_zero),  32'h0);

        // Shifts of 0x81, then XOR of both shift results
        issue8(OP_ADD, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b1, 8'h81, 8'h00, nb);
        issue8(OP_SHL, 4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, nb);
        chk("shl_out",   32'(bus8.alu_out),   32'h02);
        chk("shl_carry", 32'(bus8.alu_carry), 32'h1);
        issue8(OP_SHR, 4'd7, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, nb);
        chk("shr_out",   32'(bus8.alu_out),   32'h40);
        chk("shr_carry", 32'(bus8.alu_carry), 32'h1);
        issue8(OP_XOR, 4'd8, 4'd9, 4'd10, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, nb);
        chk("xor_out",   32'(bus8.alu_out),   32'h42);
        chk("xor_carry", 32'(bus8.alu_carry), 32'h0);
        issue8(OP_NOT, 4'd1, 4'd0, 4'd13, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, nb);
        chk("not_out",   32'(bus8.alu_out),   32'hF0);
        issue8(OP_AND, 4'd1, 4'd0, 4'd13, 1'b0, 1'b0, 1'b1, 8'h00, 8'h3C, nb);
        chk("and_out",   32'(bus8.alu_out),   32'h0C);

        // Three stalled cycles between dependent ops
        issue8(OP_ADD, 4'd1, 4'd0, 4'd11, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, nb);
        chk("pre_stall_out", 32'(bus8.alu_out), 32'h10);
        bus8.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_result_valid", 32'(bus8.result_valid), 32'h0);
            chk("stall_alu_hold",     32'(bus8.alu_out),      32'h10);
            chk("stall_issue_ready",  32'(bus8.issue_ready),  32'h0);
        end
        bus8.stall = 1'b0;
        issue8(OP_ADD, 4'd11, 4'd0, 4'd12, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, nb);
        chk("post_stall_read_a", 32'(bus8.read_a),  32'h10);
        chk("post_stall_out",    32'(bus8.alu_out), 32'h11);

        // R0 hard-wired to zero on the 16-bit instance
        issue16(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 16'hBEEF);
        chk("w16_r0_out", 32'(bus16.alu_out), 32'hBEEF);
        issue16(OP_OR, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 16'h0000);
        chk("r0_read",      32'(bus16.read_a),   32'h0000);
        chk("r0_read_zero", 32'(bus16.alu_zero), 32'h1);
        issue16(OP_ADD, 5'd0, 5'd0, 5'd31, 1'b1, 1'b1, 16'hBEEF);
        issue16(OP_OR, 5'd31, 5'd0, 5'd1, 1'b0, 1'b0, 16'h0000);
        chk("r31_read_a", 32'(bus16.read_a),  32'hBEEF);
        chk("r0_read_b",  32'(bus16.read_b),  32'h0000);
        chk("r31_or_out", 32'(bus16.alu_out), 32'hBEEF);
        issue16(OP_SHL, 5'd31, 5'd0, 5'd2, 1'b1, 1'b1, 16'h0000);
        chk("shl16_out",   32'(bus16.alu_out),   32'h7DDE);
        chk("shl16_carry", 32'(bus16.alu_carry), 32'h1);

        // Reset during a pending write aborts it
        issue8(OP_ADD, 4'd0, 4'd0, 4'd14, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55, nb);
        chk("pre_abort_out", 32'(bus8.alu_out), 32'h55);
        rst_n = 1'b0;
        #2;
        chk("abort_alu_out", 32'(bus8.alu_out),      32'h00);
        chk("abort_valid",   32'(bus8.result_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue8(OP_OR, 4'd14, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, nb);
        chk("abort_r14", 32'(bus8.read_a), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
